// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared seven-segment definitions for the counter/display slice.
// Segment bit order on the bus is {g,f,e,d,c,b,a}; all patterns here are
// active-high (1 = segment lit), polarity is applied by the user of the pattern.
package sevenseg_pkg;

  // Bit position of each segment within the seven-bit segment bus.
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam int SEG_W = int'(SEG_G) + 1;

  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Non-decimal nibble values show nothing rather than a garbage glyph.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] v);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    if (v <= 4'd9) s = SEG_DIGIT[v];
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_count_mux_if.sv
// sevenseg_count_mux_if: control inputs and display/pulse outputs of the
// multiplexed counter. The master side is the fabric logic that enables and
// clears the count; the slave side is the counter/display block itself.
interface sevenseg_count_mux_if
  import sevenseg_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic             en;
  logic             clr;
  logic [SEG_W-1:0] seg;
  logic [DIGITS-1:0] an;
  logic             tick;
  logic             wrap;

  modport master (output en, clr, input seg, an, tick, wrap);
  modport slave  (input en, clr, output seg, an, tick, wrap);
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the BCD counter. carry is combinational so a chain
// of these ripples an increment through all-9 digits within a single cycle.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  // Decade count 0..9; reset and clear both win over an increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
    end
  end

  assign carry = inc && (value == 4'd9);

endmodule

// File: rtl/sevenseg_count_mux.sv
// sevenseg_count_mux: prescaled DIGITS-wide BCD counter with a time-multiplexed
// seven-segment drive. Optional leading-zero blanking is enabled by defining
// the macro SEVENSEG_LZB_EN; without it every digit shows its decoded value.
module sevenseg_count_mux
  import sevenseg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 20000000,
  parameter int SCAN_DIV       = 20000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic clk,
  input logic rst,
  sevenseg_count_mux_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PSC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]     psc;
  logic [SW-1:0]     scan;
  logic [IW-1:0]     idx;
  logic              tick;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] carry;
  logic [3:0]        val [DIGITS];
  logic [DIGITS-1:0] blank;
  logic [3:0]        cur_val;
  logic              cur_blank;
  logic [DIGITS-1:0] sel;
  logic [SEG_W-1:0]  seg_hi;
  logic [SEG_W-1:0]  seg_q;
  logic [DIGITS-1:0] an_q;

  // A clear in the terminal cycle wins, so no tick (and hence no wrap) escapes.
  assign tick = bus.en && !bus.clr && !rst && (psc == PSC_LAST);

  // Prescaler: holds its value while disabled so no partial period is lost.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      psc <= '0;
    end else if (bus.en) begin
      psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign inc[k] = tick;
    end else begin : g_upper
      assign inc[k] = carry[k-1];
    end
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clr),
      .inc   (inc[k]),
      .value (val[k]),
      .carry (carry[k])
    );
  end

  // The top digit only carries out when every digit was 9, i.e. a rollover.
  assign bus.wrap = carry[DIGITS-1];
  assign bus.tick = tick;

  // Scan timer and digit index run freely, independent of the count enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan <= '0;
      idx  <= '0;
    end else if (scan == SCAN_LAST) begin
      scan <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  // Blank mask: digit k>0 is dark when it and every higher digit are zero.
  always_comb begin
    blank = '0;
`ifdef SEVENSEG_LZB_EN
    for (int k = DIGITS - 1; k > 0; k--) begin
      blank[k] = 1'b1;
      for (int j = k; j < DIGITS; j++) begin
        if (val[j] != 4'd0) blank[k] = 1'b0;
      end
    end
`endif
  end

  // Select the nibble, blank flag and anode line for the current scan index.
  always_comb begin
    cur_val   = 4'd0;
    cur_blank = 1'b0;
    sel       = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_val   = val[k];
        cur_blank = blank[k];
        sel[k]    = 1'b1;
      end
    end
  end

  assign seg_hi = cur_blank ? SEG_BLANK : bcd_to_seg(cur_val);

  // Register seg and an together so the pins never show a mismatched pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
      an_q  <= (AN_ACTIVE_LOW != 0) ? ~sel : sel;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_sevenseg_count_mux.sv
// tb_sevenseg_count_mux: scoreboard bench for the multiplexed BCD counter.
// Build with SEVENSEG_LZB_EN defined or not; the reference model follows it.
module tb_sevenseg_count_mux;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int MODULUS  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sevenseg_count_mux_if #(.DIGITS(DIGITS)) bus ();

  sevenseg_count_mux #(
    .DIGITS         (DIGITS),
    .TICK_DIV       (TICK_DIV),
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       tick;
    logic       wrap;
  } obs_t;

  obs_t expq[$];

  int checks     = 0;
  int passes     = 0;
  int exp_wraps  = 0;
  int seen_wraps = 0;
  int cycle      = 0;
  bit mon_on     = 1'b0;

  // Reference model state: plain integers for count, prescale phase and scan.
  int         model_psc;
  int         model_count;
  int         model_scan;
  int         model_idx;
  logic [6:0] model_seg;
  logic [1:0] model_an;

  logic [6:0] lit [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Active-low pattern the board should show for decimal position k of count.
  function automatic logic [6:0] model_digit_seg(input int count, input int k);
    int         d;
    logic [6:0] hi;
    d  = (count / (10 ** k)) % 10;
    hi = lit[d];
`ifdef SEVENSEG_LZB_EN
    if (k > 0 && count < 10 ** k) hi = 7'h00;
`endif
    return ~hi;
  endfunction

  // Drive one cycle of inputs, queue the expected observation, advance model.
  task automatic applyStimulus(input bit r, input bit e, input bit c);
    obs_t o;
    bit   t;
    rst     = r;
    bus.en  = e;
    bus.clr = c;
    t      = !r && !c && e && (model_psc == TICK_DIV - 1);
    o.seg  = model_seg;
    o.an   = model_an;
    o.tick = t;
    o.wrap = t && (model_count == MODULUS - 1);
    if (o.wrap) exp_wraps++;
    expq.push_back(o);
    if (r) begin
      model_seg = 7'h7F;
      model_an  = 2'b11;
    end else begin
      model_seg = model_digit_seg(model_count, model_idx);
      model_an  = ~(2'b01 << model_idx);
    end
    if (r || c) model_psc = 0;
    else if (e) model_psc = (model_psc + 1) % TICK_DIV;
    if (r || c) model_count = 0;
    else if (t) model_count = (model_count + 1) % MODULUS;
    if (r) begin
      model_scan = 0;
      model_idx  = 0;
    end else begin
      if (model_scan == SCAN_DIV - 1) model_idx = (model_idx + 1) % DIGITS;
      model_scan = (model_scan + 1) % SCAN_DIV;
    end
    @(posedge clk);
    #1;
  endtask

  // Compare one queued expectation against what the DUT presents right now.
  task automatic checkOutput(input obs_t e);
    obs_t a;
    a = {bus.seg, bus.an, bus.tick, bus.wrap};
    checks++;
    if (a === e) begin
      passes++;
    end else begin
      $display("[TB] FAIL cycle %0d outputs: got seg=%h an=%b tick=%b wrap=%b, expected seg=%h an=%b tick=%b wrap=%b",
               cycle, a.seg, a.an, a.tick, a.wrap, e.seg, e.an, e.tick, e.wrap);
    end
    if (bus.wrap === 1'b1) seen_wraps++;
  endtask

  // Monitor: on every falling edge pop the next expectation and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cycle++;
        if (expq.size() == 0) begin
          checks++;
          $display("[TB] FAIL cycle %0d scoreboard: got empty queue, expected an entry", cycle);
        end else begin
          checkOutput(expq.pop_front());
        end
      end
    end
  end

  initial begin
    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    rst         = 1'b1;
    model_psc   = 0;
    model_count = 0;
    model_scan  = 0;
    model_idx   = 0;
    model_seg   = 7'h7F;
    model_an    = 2'b11;
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    $display("[TB] reset");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] counting through a full wrap");
    repeat (TICK_DIV * MODULUS + 8) applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] enable hold at prescale 2");
    for (int i = 0; i < TICK_DIV && model_psc != 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] clear in terminal cycle at 99");
    for (int i = 0; i < TICK_DIV * MODULUS + TICK_DIV &&
                    !(model_count == MODULUS - 1 && model_psc == TICK_DIV - 1); i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] randomized control");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0);
    end

    mon_on = 1'b0;
    checks++;
    if (seen_wraps == exp_wraps) begin
      passes++;
    end else begin
      $display("[TB] FAIL wrap_count: got %0d pulses, expected %0d", seen_wraps, exp_wraps);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_count_mux.md
# sevenseg_count_mux

Parametrised multi-digit decimal counter with time-multiplexed seven-segment drive for the Vaman board. A prescaler derived from `clk` advances a DIGITS-wide BCD counter, and a scan counter multiplexes the digits onto a shared segment bus. It supersedes the single-digit blink drivers, sits directly on the board pins, and exposes tick/wrap pulses for other fabric logic.

## Interface
- `DIGITS`, 4: number of BCD digits and anode lines; legal range 1..8.
- `TICK_DIV`, 20000000: `clk` cycles per count increment; must be ≥2.
- `SCAN_DIV`, 20000: `clk` cycles each digit is displayed; must be ≥1.
- `SEG_ACTIVE_LOW`, 1: 1 means a lit segment is driven 0.
- `AN_ACTIVE_LOW`, 1: 1 means the selected anode is driven 0.

- `clk` in 1: the sole clock, taken from `Sys_Clk0` of the cell macro.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: count enable; prescaler holds while low.
- `clr` in 1: synchronous clear of the prescaler and the BCD count.
- `seg` out 7: segment bus, {g,f,e,d,c,b,a}, polarity set by `SEG_ACTIVE_LOW`.
- `an` out DIGITS: one-hot digit select, polarity set by `AN_ACTIVE_LOW`; bit 0 is the least-significant digit.
- `tick` out 1: one-cycle pulse on each count increment.
- `wrap` out 1: one-cycle pulse when the count rolls from all-9s to 0.

## Operation
- Prescaler is $clog2(TICK_DIV) bits wide and counts 0..TICK_DIV-1 while `en`=1.
- Terminal count with `en`=1 produces `tick` and increments the BCD count.
- BCD count is DIGITS nibbles with ripple carry; each nibble counts 0..9.
- When all nibbles are 9, the next increment loads all zeros and asserts `wrap` together with `tick`.
- `clr`=1 zeroes the prescaler and the count, regardless of `en`, and suppresses `tick` and `wrap` in that cycle.
- Priority order: `rst` > `clr` > increment.
- Scan counter counts 0..SCAN_DIV-1 free-running; `en` does not gate it.
- At scan terminal count, the digit index advances 0→DIGITS-1 and then wraps to 0.
- `seg` and `an` are registered from the current index and the current count.
- Decoder, active-high form: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibble values 10..15 decode to blank.
- Polarity is applied after decode.

## Timing
- Reset values:
  - `seg` = all segments off (7'h7F when active-low).
  - `an` = all digits off.
  - `tick`, `wrap` = 0; count, prescaler, scan counter and index = 0.
- First cycle after `rst` falls: `an` selects digit 0 and `seg` shows digit 0's value.
- `tick` and `wrap` are combinational from prescaler state and `en`; the count updates on the same edge.
- A count change appears on `seg` one cycle after the update, if that digit is currently selected.
- Index update to `an`/`seg` change: 1 cycle; `an` and `seg` always change on the same edge.
- `en` deasserted mid-prescale: prescaler value holds and resumes without loss when `en` returns.
- `rst` or `clr` mid-scan or mid-prescale: takes effect on the next edge with no partial-state residue.
- DIGITS=1: index stays 0 and `an` is constant-selected.

## Configuration
- Macro `SEVENSEG_LZB_EN` controls leading-zero blanking.
- Defined: a digit k>0 is blanked when it and all higher digits are 0. Its `an` still scans and `seg` is all-off. Digit 0 is never blanked.
- Undefined: every digit displays its decoded value.

## Structure
- Shared package `sevenseg_pkg` holds:
  - segment constants `SEG_DIGIT[0:9]` and `SEG_BLANK`;
  - function `bcd_to_seg`;
  - the segment bit-order definition.
- Sub-module `bcd_digit` is a single decade counter with `inc` and `clr` inputs and `value` and `carry` outputs. It is instantiated DIGITS times in a generate loop.

## Test plan
Bench parameters: DIGITS=2, TICK_DIV=4, SCAN_DIV=2, both polarities active-low.
- Reset: hold `rst`=1 for 3 cycles → `seg`=7'h7F, `an`=2'b11, `tick`=0. First cycle after release → `an`=2'b10, `seg`=7'h40.
- Counting: `en`=1 from reset → `tick` pulses every 4 cycles. After 10 ticks, digit 1 selected → `seg`=7'h79 and digit 0 → `seg`=7'h40.
- Wrap: 100 ticks → count 99→00, `wrap` pulses exactly once and coincides with the 100th `tick`.
- Enable hold: `en`=0 for 10 cycles with the prescaler at 2 → no `tick`. Re-enable → `tick` after exactly 2 more cycles.
- Clear collision: `clr`=1 in a terminal-count cycle at count 99 → count 00, `tick`=0, `wrap`=0.
- Blanking: count 05 → digit 1 `seg`=7'h7F with `SEVENSEG_LZB_EN` defined, 7'h40 without it.
